// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {S_IDLE, S_WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter shared by the fetch unit (IF) and the load/store
// unit (LS). One access outstanding at a time, fixed memory read latency.
// LS has priority; after STARVE_MAX back-to-back LS grants with IF waiting,
// IF wins once. A pipeline redirect (if_flush) drops the pending fetch reply.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no access in flight; arbitrate and issue to memory this cycle
//   S_WAIT | access in flight; counting down the memory latency
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t  state;
  arb_owner_t  owner;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          drop_q;
  logic          rsp_q;
  logic [31:0]   rdata_q;
  logic          grant;

  // Grant selection: LS first unless IF has waited through a full LS streak.
  always_comb begin
    ls_gnt = 1'b0;
    if_gnt = 1'b0;
    if (state == S_IDLE) begin
      if (ls_req && (!if_req || (streak < SW'(STARVE_MAX)))) ls_gnt = 1'b1;
      else if (if_req)                                       if_gnt = 1'b1;
    end
  end

  assign grant = if_gnt | ls_gnt;

  // Memory issue port: driven from the winner in the grant cycle, zero otherwise.
  always_comb begin
    mem_req   = grant;
    mem_we    = ls_gnt & ls_we;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      mem_be    = BE_FULL;
    end
  end

  // Access sequencer: latch owner on grant, count latency, capture read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      cnt     <= '0;
      rsp_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      rsp_q <= 1'b0;
      if (state == S_IDLE) begin
        if (grant) begin
          state <= S_WAIT;
          owner <= ls_gnt ? OWN_LS : OWN_IF;
          we_q  <= ls_gnt & ls_we;
          cnt   <= CW'(MEM_LAT);
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rdata_q <= we_q ? 32'h0 : mem_rdata;
          rsp_q   <= 1'b1;
          state   <= S_IDLE;
        end
      end
    end
  end

  // Starvation streak: counts LS grants taken while IF was also asking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (ls_gnt) begin
      streak <= if_req ? streak + SW'(1) : '0;
    end else if (if_gnt) begin
      streak <= '0;
    end
  end

  // Drop flag: any flush from the IF grant up to the reply kills that reply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (grant) begin
      drop_q <= if_gnt & if_flush;
    end else begin
      drop_q <= drop_q | if_flush;
    end
  end

  // A flush in the reply cycle itself must also suppress the pulse.
  assign if_rvalid = rsp_q && (owner == OWN_IF) && !drop_q && !if_flush;
  assign ls_rvalid = rsp_q && (owner == OWN_LS);
  assign if_rdata  = rdata_q;
  assign ls_rdata  = rdata_q;

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Arbitrates a single shared single-port instruction/data memory between the fetch unit (IF) and the load/store unit (LS) of the RISC-V lite core. It holds one outstanding access at a time and sequences it through a fixed-latency memory. It returns read data to whichever requester owns the access. It gives LS priority, with a starvation guard for IF, and supports dropping an in-flight fetch on a pipeline redirect.

## Interface
- MEM_LAT, 1: memory read latency in cycles, ≥1
- STARVE_MAX, 4: consecutive LS grants allowed while IF waits, ≥1
- CLK  in  1  clock; one clock domain
- RST_N  in  1  reset, asynchronous, active-low
- IF_REQ  in  1  fetch request
- IF_ADDR  in  32  fetch byte address
- IF_FLUSH  in  1  discard any in-flight fetch response
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  fetch data valid, one-cycle pulse
- IF_RDATA  out  32  fetch data
- LS_REQ  in  1  load/store request
- LS_WE  in  1  1 = store
- LS_ADDR  in  32  byte address
- LS_WDATA  in  32  store data
- LS_BE  in  4  byte enables
- LS_GNT  out  1  LS request accepted this cycle
- LS_RVALID  out  1  load data / store ack, one-cycle pulse
- LS_RDATA  out  32  load data; 0 for stores
- MEM_REQ  out  1  memory access issued this cycle
- MEM_WE  out  1  write strobe
- MEM_ADDR  out  32  address
- MEM_WDATA  out  32  write data
- MEM_BE  out  4  byte enables; 4'hF for fetches
- MEM_RDATA  in  32  valid in the MEM_LAT-th cycle after issue

## Operation
- States:
  - IDLE: accepts requests.
  - WAIT: access in flight.
- Arbitration in IDLE only. Both grants are combinational from the requests and the state.
  - Only one requester active: that requester wins.
  - Both active and STREAK < STARVE_MAX: LS wins.
  - Both active and STREAK == STARVE_MAX: IF wins.
- STREAK (width clog2(STARVE_MAX+1)) updates on each grant:
  - LS grant with IF_REQ=1: increments.
  - LS grant with IF_REQ=0: cleared.
  - IF grant: cleared.
- On a grant:
  - MEM_REQ=1 that cycle, with MEM_* driven from the winner.
  - OWNER and WE are latched.
  - CNT is loaded with MEM_LAT.
  - Next state is WAIT.
- In WAIT:
  - CNT decrements each cycle.
  - When CNT==1, MEM_RDATA is captured into RDATA_Q (0 if WE) and the state returns to IDLE.
  - The RVALID of OWNER pulses in the next cycle.
- The response cycle is an IDLE cycle, so a new grant may occur in the same cycle as RVALID.
- MEM_REQ=0 in WAIT. MEM_* outputs are don't-care when MEM_REQ=0 but must not be X; drive 0.
- Flush:
  - A DROP flag is set when IF_FLUSH=1 in any cycle from the IF grant cycle through the response cycle, inclusive.
  - When DROP is set, IF_RVALID for that access is suppressed.
  - DROP is cleared on the next grant.
  - IF_FLUSH has no effect on LS accesses and does not block new grants.
- Requesters must hold REQ/ADDR/data stable until GNT. No request is ever cancelled after GNT.

## Timing
- Reset (async assert, sync release): state IDLE, CNT=0, STREAK=0, DROP=0, RDATA_Q=0.
  - All outputs are 0: GNT, RVALID, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, IF_RDATA, LS_RDATA.
  - An in-flight access is abandoned with no RVALID.
- Latency: grant in cycle T → RVALID in cycle T+MEM_LAT+1.
- Throughput: one access per MEM_LAT+1 cycles under back-to-back requests.
- RDATA holds its last value between pulses. Only the RVALID pulse is meaningful.

## Structure
- Shared package mem_arb_pkg holds:
  - typedef enum logic {S_IDLE, S_WAIT} arb_state_t
  - typedef enum logic {OWN_IF, OWN_LS} arb_owner_t
  - localparam BE_FULL = 4'hF
- Single module, no sub-module. The grant selection is a small always_comb block within it.

## Test plan
- Reset mid-WAIT (MEM_LAT=3, RST_N low in cycle T+2) → no RVALID afterwards; all outputs 0; first request after release granted immediately.
- IF only, IF_ADDR=0x10, memory returns 0x00000005, MEM_LAT=1 → IF_GNT at T, MEM_REQ/MEM_BE=4'hF at T, IF_RVALID with 0x00000005 at T+2.
- LS store: LS_WE=1, addr 0x20, WDATA 0xDEADBEEF, BE 4'h3 → MEM_WE=1 with the same fields at T; LS_RVALID with LS_RDATA=0 at T+MEM_LAT+1.
- IF and LS both held high continuously, STARVE_MAX=4 → grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF, with grants spaced MEM_LAT+1 cycles apart.
- IF_FLUSH pulsed in the cycle after the IF grant (MEM_LAT=2) → no IF_RVALID for that fetch; a following IF request is granted in the would-be response cycle and returns normally.
- IF_FLUSH coincident with a LS response → LS_RVALID still asserted with correct data.
